// File: rtl/math_equation_pkg.sv
// Shared types and helpers for the equation pipeline: rounding/output modes,
// full-width sizing and the wide round/saturate arithmetic used by the last stage.
package math_equation_pkg;

    typedef enum logic {RND_FLOOR, RND_HALF_UP} rnd_mode_e;
    typedef enum logic {OUT_WRAP, OUT_SAT} out_mode_e;

    // Helpers operate on a generous fixed width so they stay reusable across
    // parameter sets; callers sign-extend into it and truncate out of it.
    localparam int MAXW = 128;
    typedef logic signed [MAXW-1:0] wide_t;

    function automatic int fw(input int width, input int kw);
        return kw + 2*width + 3;
    endfunction

    function automatic wide_t round_shift(input wide_t x, input int rshift, input rnd_mode_e mode);
        wide_t half;
        half = '0;
        if (mode == RND_HALF_UP && rshift > 0) half = wide_t'(1) <<< (rshift - 1);
        return (x + half) >>> rshift;
    endfunction

    function automatic logic fits(input wide_t x, input int ow);
        wide_t hi;
        hi = x >>> (ow - 1);
        return (hi == '0) || (hi == '1);
    endfunction

    function automatic wide_t saturate(input wide_t x, input int ow);
        wide_t lo;
        lo = '1;
        lo = lo <<< (ow - 1);
        if (fits(x, ow)) return x;
        return x[MAXW-1] ? lo : ~lo;
    endfunction

endpackage

// File: rtl/math_equation_pipe_if.sv
// Producer/consumer handshake bundle of math_equation_pipe.
interface math_equation_pipe_if #(
    parameter int WIDTH = 16,
    parameter int KW    = 4,
    parameter int OUT_W = 38
);
    logic                    valid_i;
    logic                    ready_o;
    logic signed [WIDTH-1:0] a, b, c, d;
    logic signed [KW-1:0]    k0, k1;
    logic                    valid_o;
    logic                    ready_i;
    logic signed [OUT_W-1:0] q;
    logic                    ovf_o;
    logic [1:0]              inflight_o;

    modport master (output valid_i, a, b, c, d, k0, k1, ready_i,
                    input  ready_o, valid_o, q, ovf_o, inflight_o);
    modport slave  (input  valid_i, a, b, c, d, k0, k1, ready_i,
                    output ready_o, valid_o, q, ovf_o, inflight_o);
endinterface

// File: rtl/math_round_sat.sv
// Combinational tail of the pipeline: shift/round the full-width difference
// and wrap or clamp it into OUT_W bits, flagging values that do not fit.
module math_round_sat
    import math_equation_pkg::*;
#(
    parameter int        FW       = 39,
    parameter int        RSHIFT   = 1,
    parameter rnd_mode_e RND_MODE = RND_FLOOR,
    parameter out_mode_e OUT_MODE = OUT_WRAP,
    parameter int        OUT_W    = 38
) (
    input  logic signed [FW-1:0]    diff,
    output logic signed [OUT_W-1:0] q,
    output logic                    ovf
);
    if (FW + 1 > MAXW || OUT_W > MAXW) begin : g_bad_width
        $error("math_round_sat: operand width exceeds helper width");
    end

    wide_t wide, shifted, clamped;

    always_comb begin
        wide    = wide_t'(diff);
        shifted = round_shift(wide, RSHIFT, RND_MODE);
        ovf     = ~fits(shifted, OUT_W);
        clamped = (OUT_MODE == OUT_SAT) ? saturate(shifted, OUT_W) : shifted;
        q       = clamped[OUT_W-1:0];
    end

endmodule

// File: rtl/math_equation_pipe.sv
// Three-stage q = round_shift((k0 + k1*c)*(a - b) - (d <<< DSHIFT), RSHIFT)
// pipeline with a whole-pipe stall driven by the consumer's ready.
module math_equation_pipe
    import math_equation_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int KW     = 4,
    parameter int DSHIFT = 2,
    parameter int RSHIFT = 1,
    parameter int RND    = 0,
    parameter int SAT    = 0,
    parameter int OUT_W  = KW + 2*WIDTH + 3 - RSHIFT
) (
    input  logic                clk,
    input  logic                rst_n,
    math_equation_pipe_if.slave io
);
    localparam int LW = KW + WIDTH + 1;
    localparam int PW = KW + 2*WIDTH + 2;
    localparam int DW = WIDTH + DSHIFT;
    localparam int FW = fw(WIDTH, KW);

    if (DSHIFT > KW + WIDTH + 2 || RSHIFT < 0) begin : g_bad_param
        $error("math_equation_pipe: DSHIFT/RSHIFT out of range");
    end

    // vld_pipe[0]=v0, [1]=v1, [2]=valid_o; en[] are the per-stage load enables
    logic [2:0] vld_pipe, vld_nxt, en;
    logic [1:0] inflight;

    logic signed [WIDTH:0]    sub_r;
    logic signed [LW-1:0]     lin_r;
    logic signed [WIDTH-1:0]  d_r;
    logic signed [PW-1:0]     prod_r;
    logic signed [DW-1:0]     dsh_r;
    logic signed [FW-1:0]     diff_c;
    logic signed [OUT_W-1:0]  q_c, q_r;
    logic                     ovf_c, ovf_r;

    assign en[2] = ~vld_pipe[2] | io.ready_i;
    assign en[1] = ~vld_pipe[1] | en[2];
    assign en[0] = ~vld_pipe[0] | en[1];

    assign io.ready_o    = en[0];
    assign io.valid_o    = vld_pipe[2];
    assign io.q          = q_r;
    assign io.ovf_o      = ovf_r;
    assign io.inflight_o = inflight;

    always_comb begin
        vld_nxt = vld_pipe;
        if (en[0]) vld_nxt[0] = io.valid_i;
        if (en[1]) vld_nxt[1] = vld_pipe[0];
        if (en[2]) vld_nxt[2] = vld_pipe[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            inflight <= '0;
            q_r      <= '0;
            ovf_r    <= 1'b0;
        end else begin
            vld_pipe <= vld_nxt;
            inflight <= 2'(vld_nxt[0]) + 2'(vld_nxt[1]) + 2'(vld_nxt[2]);
            // Result regs only take real samples so q keeps the last result when idle.
            if (en[2] && vld_pipe[1]) begin
                q_r   <= q_c;
                ovf_r <= ovf_c;
            end
        end
    end

    // Datapath registers are intentionally unreset; the valids qualify them.
    always_ff @(posedge clk) begin
        if (en[0] && io.valid_i) begin
            sub_r <= (WIDTH+1)'(io.a) - (WIDTH+1)'(io.b);
            lin_r <= LW'(io.k0) + LW'(io.k1) * LW'(io.c);
            d_r   <= io.d;
        end
        if (en[1] && vld_pipe[0]) begin
            prod_r <= PW'(lin_r) * PW'(sub_r);
            dsh_r  <= DW'(d_r) <<< DSHIFT;
        end
    end

    assign diff_c = FW'(prod_r) - FW'(dsh_r);

    math_round_sat #(
        .FW       (FW),
        .RSHIFT   (RSHIFT),
        .RND_MODE ((RND != 0) ? RND_HALF_UP : RND_FLOOR),
        .OUT_MODE ((SAT != 0) ? OUT_SAT : OUT_WRAP),
        .OUT_W    (OUT_W)
    ) u_round_sat (
        .diff (diff_c),
        .q    (q_c),
        .ovf  (ovf_c)
    );

endmodule

// File: tb/tb_math_equation_pipe.sv
// Four parameter variants of math_equation_pipe driven in lockstep and scored
// against an arithmetic reference model with per-variant result queues.
module tb_math_equation_pipe;
    localparam int W   = 16;
    localparam int KW  = 4;
    localparam int DSH = 2;
    localparam int RSH = 1;
    localparam int OW0 = KW + 2*W + 3 - RSH;
    localparam int OW1 = 16;
    localparam int RND_C[4] = '{0, 1, 0, 0};
    localparam int SAT_C[4] = '{0, 0, 1, 0};
    localparam int OW_C[4]  = '{OW0, OW0, OW1, OW1};

    typedef logic signed [63:0] l64;
    typedef struct {
        logic signed [W-1:0]  a, b, c, d;
        logic signed [KW-1:0] k0, k1;
    } samp_t;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  valid_i, ready_i;
    samp_t cur;
    int    errors = 0, checks = 0, n_out = 0;
    bit    acc;

    samp_t sb[4][$];
    bit    hold[4];
    l64    pq[4];
    logic  po[4];

    logic       vo[4], rdy[4], ov[4];
    logic [1:0] inf[4];
    l64         qo[4];

    always #5 clk = ~clk;

    math_equation_pipe_if #(.WIDTH(W), .KW(KW), .OUT_W(OW0)) if0 ();
    math_equation_pipe_if #(.WIDTH(W), .KW(KW), .OUT_W(OW0)) if1 ();
    math_equation_pipe_if #(.WIDTH(W), .KW(KW), .OUT_W(OW1)) if2 ();
    math_equation_pipe_if #(.WIDTH(W), .KW(KW), .OUT_W(OW1)) if3 ();

    math_equation_pipe #(.WIDTH(W), .KW(KW), .DSHIFT(DSH), .RSHIFT(RSH), .RND(0), .SAT(0))
        u_def (.clk(clk), .rst_n(rst_n), .io(if0));
    math_equation_pipe #(.WIDTH(W), .KW(KW), .DSHIFT(DSH), .RSHIFT(RSH), .RND(1), .SAT(0))
        u_rnd (.clk(clk), .rst_n(rst_n), .io(if1));
    math_equation_pipe #(.WIDTH(W), .KW(KW), .DSHIFT(DSH), .RSHIFT(RSH), .RND(0), .SAT(1), .OUT_W(OW1))
        u_sat (.clk(clk), .rst_n(rst_n), .io(if2));
    math_equation_pipe #(.WIDTH(W), .KW(KW), .DSHIFT(DSH), .RSHIFT(RSH), .RND(0), .SAT(0), .OUT_W(OW1))
        u_wrap (.clk(clk), .rst_n(rst_n), .io(if3));

    assign vo[0] = if0.valid_o;  assign vo[1] = if1.valid_o;
    assign vo[2] = if2.valid_o;  assign vo[3] = if3.valid_o;
    assign rdy[0] = if0.ready_o; assign rdy[1] = if1.ready_o;
    assign rdy[2] = if2.ready_o; assign rdy[3] = if3.ready_o;
    assign ov[0] = if0.ovf_o;    assign ov[1] = if1.ovf_o;
    assign ov[2] = if2.ovf_o;    assign ov[3] = if3.ovf_o;
    assign inf[0] = if0.inflight_o; assign inf[1] = if1.inflight_o;
    assign inf[2] = if2.inflight_o; assign inf[3] = if3.inflight_o;
    assign qo[0] = l64'(if0.q);  assign qo[1] = l64'(if1.q);
    assign qo[2] = l64'(if2.q);  assign qo[3] = l64'(if3.q);

    task automatic chk(input string tag, input l64 obs, input l64 exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply();
        if0.valid_i = valid_i; if0.ready_i = ready_i; if0.a = cur.a; if0.b = cur.b;
        if0.c = cur.c; if0.d = cur.d; if0.k0 = cur.k0; if0.k1 = cur.k1;
        if1.valid_i = valid_i; if1.ready_i = ready_i; if1.a = cur.a; if1.b = cur.b;
        if1.c = cur.c; if1.d = cur.d; if1.k0 = cur.k0; if1.k1 = cur.k1;
        if2.valid_i = valid_i; if2.ready_i = ready_i; if2.a = cur.a; if2.b = cur.b;
        if2.c = cur.c; if2.d = cur.d; if2.k0 = cur.k0; if2.k1 = cur.k1;
        if3.valid_i = valid_i; if3.ready_i = ready_i; if3.a = cur.a; if3.b = cur.b;
        if3.c = cur.c; if3.d = cur.d; if3.k0 = cur.k0; if3.k1 = cur.k1;
    endtask

    // Reference: plain 64-bit arithmetic on the equation, then wrap or clamp.
    function automatic void model(input samp_t s, input int i, output l64 qe, output l64 oe);
        longint diff, sv, lo, hi;
        diff = (longint'(s.k0) + longint'(s.k1) * longint'(s.c)) * (longint'(s.a) - longint'(s.b))
               - longint'(s.d) * (longint'(1) <<< DSH);
        if (RND_C[i] != 0 && RSH > 0) diff = diff + (longint'(1) <<< (RSH - 1));
        sv = diff >>> RSH;
        lo = -(longint'(1) <<< (OW_C[i] - 1));
        hi = -lo - 1;
        oe = (sv < lo || sv > hi) ? l64'(1) : l64'(0);
        if (SAT_C[i] != 0) qe = (sv < lo) ? lo : ((sv > hi) ? hi : sv);
        else               qe = (sv <<< (64 - OW_C[i])) >>> (64 - OW_C[i]);
    endfunction

    function automatic samp_t mk(input int a, b, c, d, k0, k1);
        samp_t s;
        s.a = 16'(a); s.b = 16'(b); s.c = 16'(c); s.d = 16'(d);
        s.k0 = 4'(k0); s.k1 = 4'(k1);
        return s;
    endfunction

    function automatic logic signed [W-1:0] pick16();
        case ($urandom_range(0, 7))
            0: return 16'sh7fff;
            1: return 16'sh8000;
            2: return 16'sh0000;
            3: return 16'shffff;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic samp_t rnd_samp();
        samp_t s;
        s.a = pick16(); s.b = pick16(); s.c = pick16(); s.d = pick16();
        s.k0 = 4'($urandom); s.k1 = 4'($urandom);
        return s;
    endfunction

    // One clock: check state, score transfers at the coming edge, then advance.
    task automatic step();
        samp_t s;
        l64    qe, oe;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("inflight", l64'(inf[i]), l64'(sb[i].size()));
            chk("ready_o", l64'(rdy[i]), l64'(!(sb[i].size() == 3 && !ready_i)));
            if (hold[i]) begin
                chk("hold_vld", l64'(vo[i]), l64'(1));
                chk("hold_q", qo[i], pq[i]);
                chk("hold_ovf", l64'(ov[i]), l64'(po[i]));
            end
            if (vo[i] && ready_i) begin
                if (sb[i].size() == 0) chk("spurious_out", l64'(1), l64'(0));
                else begin
                    s = sb[i].pop_front();
                    model(s, i, qe, oe);
                    chk("q", qo[i], qe);
                    chk("ovf", l64'(ov[i]), oe);
                end
                if (i == 0) n_out++;
            end
            if (valid_i && rdy[i]) sb[i].push_back(cur);
            hold[i] = vo[i] && !ready_i;
            pq[i] = qo[i];
            po[i] = ov[i];
        end
        acc = valid_i && rdy[0];
        @(posedge clk);
        #1;
    endtask

    task automatic send_wait(input samp_t s, output int lat);
        int n;
        cur = s; valid_i = 1'b1; apply();
        n = 0;
        do begin step(); n++; end while (!acc && n < 20);
        chk("accept", l64'(acc), l64'(1));
        valid_i = 1'b0; apply();
        n = 0;
        while (!vo[0] && n < 20) begin step(); n++; end
        chk("out_timeout", l64'(vo[0]), l64'(1));
        lat = n + 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int    lat, n, sent, stall;
        bit    full;
        samp_t strm[6];

        rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        cur = mk(0, 0, 0, 0, 0, 0); apply();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_vld", l64'(vo[i]), l64'(0));
            chk("rst_q", qo[i], l64'(0));
            chk("rst_ovf", l64'(ov[i]), l64'(0));
            chk("rst_inflight", l64'(inf[i]), l64'(0));
        end
        rst_n = 1'b1;

        send_wait(mk(10, 4, 2, 3, 1, 3), lat);
        chk("latency", l64'(lat), l64'(3));
        chk("t1_q", qo[0], l64'(15));
        chk("t1_ovf", l64'(ov[0]), l64'(0));
        step();

        send_wait(mk(-5, 0, 0, 0, 1, 3), lat);
        chk("floor_q", qo[0], l64'(-3));
        chk("halfup_q", qo[1], l64'(-2));
        step();

        send_wait(mk(-32768, 32767, 0, 0, 1, 0), lat);
        chk("sub_growth_q", qo[0], l64'(-32768));
        step();

        send_wait(mk(32767, -32768, 32767, 0, 7, 7), lat);
        chk("sat_q", qo[2], l64'(32767));
        chk("sat_ovf", l64'(ov[2]), l64'(1));
        chk("wrap_q", qo[3], l64'(16384));
        chk("wrap_ovf", l64'(ov[3]), l64'(1));
        chk("wide_ovf", l64'(ov[0]), l64'(0));
        step();

        // Back-to-back stream with a 4-cycle consumer stall after the first result.
        for (int k = 0; k < 6; k++) strm[k] = rnd_samp();
        n_out = 0; sent = 0; stall = -1; n = 0; full = 1'b0;
        while ((sent < 6 || sb[0].size() > 0) && n < 60) begin
            valid_i = (sent < 6);
            if (sent < 6) cur = strm[sent];
            ready_i = !(stall > 0);
            apply();
            if (inf[0] == 2'd3 && !ready_i) full = 1'b1;
            step();
            if (acc) sent++;
            if (stall > 0) stall--;
            else if (stall < 0 && n_out >= 1) stall = 4;
            n++;
        end
        chk("stream_full", l64'(full), l64'(1));
        chk("stream_count", l64'(n_out), l64'(6));
        chk("stream_drain", l64'(sb[0].size()), l64'(0));

        for (int k = 0; k < 300; k++) begin
            cur = rnd_samp();
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 3) != 0);
            apply();
            step();
        end
        valid_i = 1'b0; ready_i = 1'b1; apply();
        repeat (6) step();
        for (int i = 0; i < 4; i++) chk("rand_drain", l64'(sb[i].size()), l64'(0));

        // Reset while one result is held at the output and one sample is in stage 0.
        ready_i = 1'b0; cur = rnd_samp(); valid_i = 1'b1; apply();
        step();
        valid_i = 1'b0; apply();
        n = 0;
        while (!vo[0] && n < 10) begin step(); n++; end
        cur = rnd_samp(); valid_i = 1'b1; apply();
        step();
        valid_i = 1'b0; apply();
        chk("pre_rst_inflight", l64'(inf[0]), l64'(2));
        chk("pre_rst_vld", l64'(vo[0]), l64'(1));
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("midrst_vld", l64'(vo[i]), l64'(0));
            chk("midrst_inflight", l64'(inf[i]), l64'(0));
            sb[i].delete();
            hold[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1; ready_i = 1'b1; apply();
        repeat (3) step();
        send_wait(mk(10, 4, 2, 3, 1, 3), lat);
        chk("post_rst_latency", l64'(lat), l64'(3));
        chk("post_rst_q", qo[0], l64'(15));
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
